// File: rtl/alu_muldiv_pkg.sv
// Shared types for the multiply/divide unit: control bundle, ALU func codes,
// status bundle and the iterative FSM state encoding.
`timescale 1ns/100ps
package alu_muldiv_pkg;

  typedef struct packed {
    logic clock;
    logic reset;
  } util_control_t;

  typedef enum logic [3:0] {
    ALU_FUNC_ADD   = 4'h0,
    ALU_FUNC_SUB   = 4'h1,
    ALU_FUNC_AND   = 4'h2,
    ALU_FUNC_OR    = 4'h3,
    ALU_FUNC_XOR   = 4'h4,
    ALU_FUNC_SLT   = 4'h5,
    ALU_FUNC_SLL   = 4'h6,
    ALU_FUNC_SRL   = 4'h7,
    ALU_FUNC_SRA   = 4'h8,
    ALU_FUNC_MULT  = 4'h9,
    ALU_FUNC_MULTU = 4'hA,
    ALU_FUNC_DIV   = 4'hB,
    ALU_FUNC_DIVU  = 4'hC,
    ALU_FUNC_MTHI  = 4'hD,
    ALU_FUNC_MTLO  = 4'hE,
    ALU_FUNC_NOP   = 4'hF
  } alu_func_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic divzero;
  } alu_status_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIX  = 2'd3
  } alu_muldiv_state_t;

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of the multiply/divide datapath: right-shifting add for
// multiply, restoring trial subtract for divide.
`timescale 1ns/100ps
module alu_muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              i_is_div,
  input  logic [DATA_W:0]   i_acc,
  input  logic [DATA_W-1:0] i_q,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W:0]   o_acc,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shifted;
  logic [DATA_W+1:0] w_trial;

  always_comb begin
    w_sum     = i_acc + (i_q[0] ? {1'b0, i_b} : '0);
    w_shifted = {i_acc[DATA_W-1:0], i_q[DATA_W-1]};
    w_trial   = {1'b0, w_shifted} - {2'b00, i_b};
    // Divide keeps the partial remainder in acc and shifts quotient bits into q.
    if (i_is_div) begin
      if (!w_trial[DATA_W+1]) begin
        o_acc = w_trial[DATA_W:0];
        o_q   = {i_q[DATA_W-2:0], 1'b1};
      end else begin
        o_acc = w_shifted;
        o_q   = {i_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      o_acc = {1'b0, w_sum[DATA_W:1]};
      o_q   = {w_sum[0], i_q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair.
// Define ALU_MULDIV_EARLY_EN to end multiplies once the remaining multiplier bits are zero.
`timescale 1ns/100ps
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input  util_control_t     ctrl,
  input  logic              start,
  input  alu_func_t         func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic              rd_req,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic              divzero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic w_clk, w_rst;
  assign w_clk = ctrl.clock;
  assign w_rst = ctrl.reset;

  alu_muldiv_state_t r_state, w_next_state;
  logic [DATA_W:0]     r_acc, w_step_acc;
  logic [DATA_W-1:0]   r_q, r_b, w_step_q;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div, r_neg_q, r_neg_r, r_done, r_divzero;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic                w_is_mul, w_is_div, w_signed, w_div0, w_neg_q;
  logic                w_mul_last, w_last, w_busy;
  logic [DATA_W-1:0]   w_abs1, w_abs2, w_quot, w_rem;
  logic [2*DATA_W-1:0] w_mag, w_prod;
  alu_status_t         w_status;

  always_comb begin
    w_is_mul = (func == ALU_FUNC_MULT) || (func == ALU_FUNC_MULTU);
    w_is_div = (func == ALU_FUNC_DIV)  || (func == ALU_FUNC_DIVU);
    w_signed = (func == ALU_FUNC_MULT) || (func == ALU_FUNC_DIV);
    w_abs1   = (w_signed && data1[DATA_W-1]) ? -data1 : data1;
    w_abs2   = (w_signed && data2[DATA_W-1]) ? -data2 : data2;
    w_div0   = w_is_div && (data2 == '0);
    w_neg_q  = w_signed && (data1[DATA_W-1] ^ data2[DATA_W-1]);
  end

  alu_muldiv_step #(.DATA_W(DATA_W)) u_step (
    .i_is_div (r_state == MD_DIV),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_b),
    .o_acc    (w_step_acc),
    .o_q      (w_step_q)
  );

`ifdef ALU_MULDIV_EARLY_EN
  // The low r_cnt-1 bits of the shifted q are the multiplier bits not yet consumed.
  logic [DATA_W-1:0] w_rem_mask;
  assign w_rem_mask = (DATA_W'(1) << (r_cnt - CNT_W'(1))) - DATA_W'(1);
  assign w_mul_last = (r_cnt == CNT_W'(1)) || ((w_step_q & w_rem_mask) == '0);
`else
  assign w_mul_last = (r_cnt == CNT_W'(1));
`endif
  assign w_last = (r_state == MD_DIV) ? (r_cnt == CNT_W'(1)) : w_mul_last;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) r_state <= MD_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: default-assign every always_comb output first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MD_IDLE: if (start) begin
        if (w_is_mul)      w_next_state = MD_MUL;
        else if (w_is_div) w_next_state = w_div0 ? MD_FIX : MD_DIV;
      end
      MD_MUL, MD_DIV: if (w_last) w_next_state = MD_FIX;
      MD_FIX:  w_next_state = MD_IDLE;
      default: w_next_state = MD_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != MD_IDLE);
    w_status = '{busy: w_busy, done: r_done, divzero: r_divzero};
  end

  // An early-terminated multiply still owes r_cnt right shifts of the product.
  assign w_mag  = {r_acc[DATA_W-1:0], r_q} >> r_cnt;
  assign w_prod = r_neg_q ? -w_mag : w_mag;
  assign w_quot = r_neg_q ? -r_q : r_q;
  assign w_rem  = r_neg_r ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_acc     <= '0;
      r_q       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: if (start) begin
          if (w_is_mul || w_is_div) begin
            r_acc     <= '0;
            r_cnt     <= CNT_W'(DATA_W);
            r_is_div  <= w_is_div;
            r_divzero <= w_div0;
            r_neg_q   <= w_neg_q;
            r_neg_r   <= w_signed && data1[DATA_W-1];
            r_q       <= w_is_mul ? w_abs2 : (w_div0 ? data1 : w_abs1);
            r_b       <= w_is_mul ? w_abs1 : w_abs2;
          end else if (func == ALU_FUNC_MTHI) begin
            r_hi      <= data1;
            r_done    <= 1'b1;
            r_divzero <= 1'b0;
          end else if (func == ALU_FUNC_MTLO) begin
            r_lo      <= data1;
            r_done    <= 1'b1;
            r_divzero <= 1'b0;
          end
        end
        MD_MUL, MD_DIV: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        MD_FIX: begin
          r_done <= 1'b1;
          if (r_divzero) begin
            r_hi <= r_q;
            r_lo <= '1;
          end else if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = w_status.busy;
  assign done    = w_status.done;
  assign divzero = w_status.divzero;
  assign stall   = rd_req & w_busy;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv at DATA_W=4: directed vector table,
// multi-cycle corner sequences and randomized ops against an arithmetic model.
`timescale 1ns/100ps
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

`ifdef ALU_MULDIV_EARLY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  util_control_t ctrl;
  logic start = 1'b0;
  alu_func_t func = ALU_FUNC_NOP;
  logic [3:0] data1 = '0, data2 = '0;
  logic rd_req = 1'b0;
  logic busy, done, stall, divzero;
  logic [3:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  assign ctrl = '{clock: clk, reset: rst};
  always #1 clk = ~clk;

  alu_muldiv #(.DATA_W(4)) dut (
    .ctrl(ctrl), .start(start), .func(func), .data1(data1), .data2(data2),
    .rd_req(rd_req), .busy(busy), .done(done), .stall(stall),
    .divzero(divzero), .hi(hi), .lo(lo)
  );

  typedef struct {
    alu_func_t  f;
    logic [3:0] a, b, e_hi, e_lo;
    logic       e_dz;
    int         e_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned operand values.
  function automatic void model(input alu_func_t f, input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] e_hi, output logic [3:0] e_lo,
                                output logic e_dz, output int e_lat);
    int sa, sb, p, q, r, mag;
    bit sgn;
    sgn = (f == ALU_FUNC_MULT) || (f == ALU_FUNC_DIV);
    sa  = sgn ? int'($signed(a)) : int'({28'd0, a});
    sb  = sgn ? int'($signed(b)) : int'({28'd0, b});
    e_dz = 1'b0;
    if (f == ALU_FUNC_MULT || f == ALU_FUNC_MULTU) begin
      p    = sa * sb;
      e_lo = 4'(p);
      e_hi = 4'(p >>> 4);
      mag  = (sb < 0) ? -sb : sb;
      if (!EARLY)        e_lat = 5;
      else if (mag == 0) e_lat = 2;
      else               e_lat = $clog2(mag + 1) + 1;
    end else if (b == 4'h0) begin
      e_hi = a; e_lo = 4'hF; e_dz = 1'b1; e_lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e_lo = 4'(q); e_hi = 4'(r); e_lat = 5;
    end
  endfunction

  // Issue one op, count edges from accept to the done pulse, then compare.
  task automatic run_op(input string tag, input alu_func_t f, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] e_hi, input logic [3:0] e_lo,
                        input logic e_dz, input int e_lat);
    int n, busy_cnt;
    bit seen;
    @(negedge clk); start = 1'b1; func = f; data1 = a; data2 = b;
    @(posedge clk);
    @(negedge clk); start = 1'b0; func = ALU_FUNC_NOP;
    n = 0; busy_cnt = 0; seen = done;
    while (!seen && n < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); n++;
      @(negedge clk);
      seen = done;
    end
    check({tag, " latency"}, n, e_lat);
    check({tag, " busy_cycles"}, busy_cnt, e_lat);
    check({tag, " hi"}, hi, e_hi);
    check({tag, " lo"}, lo, e_lo);
    check({tag, " divzero"}, divzero, e_dz);
    @(negedge clk);
    check({tag, " done_pulse_width"}, done, 0);
  endtask

  initial begin
    alu_func_t fl[4];
    logic [3:0] m_hi, m_lo, ra, rb;
    logic m_dz;
    int m_lat, n, ndone;

    vecs.push_back('{ALU_FUNC_MULTU, 4'hA, 4'hA, 4'h6, 4'h4, 1'b0, 5});
    vecs.push_back('{ALU_FUNC_MULT,  4'hD, 4'h5, 4'hF, 4'h1, 1'b0, EARLY ? 4 : 5});
    vecs.push_back('{ALU_FUNC_MULT,  4'h8, 4'hF, 4'h0, 4'h8, 1'b0, EARLY ? 2 : 5});
    vecs.push_back('{ALU_FUNC_DIVU,  4'h7, 4'h3, 4'h1, 4'h2, 1'b0, 5});
    vecs.push_back('{ALU_FUNC_DIV,   4'h9, 4'h2, 4'hF, 4'hD, 1'b0, 5});
    vecs.push_back('{ALU_FUNC_DIV,   4'h8, 4'hF, 4'h0, 4'h8, 1'b0, 5});
    vecs.push_back('{ALU_FUNC_DIVU,  4'h5, 4'h0, 4'h5, 4'hF, 1'b1, 1});
    vecs.push_back('{ALU_FUNC_MULTU, 4'h5, 4'h1, 4'h0, 4'h5, 1'b0, EARLY ? 2 : 5});
    vecs.push_back('{ALU_FUNC_MULTU, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, EARLY ? 2 : 5});
    vecs.push_back('{ALU_FUNC_MTHI,  4'hA, 4'h0, 4'hA, 4'h0, 1'b0, 0});
    vecs.push_back('{ALU_FUNC_MTLO,  4'h5, 4'h0, 4'hA, 4'h5, 1'b0, 0});

    repeat (2) @(negedge clk);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset divzero", divzero, 0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
             vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_dz, vecs[i].e_lat);

    // divzero is sticky until the very next accepted start clears it.
    run_op("div0", ALU_FUNC_DIVU, 4'h3, 4'h0, 4'h3, 4'hF, 1'b1, 1);
    @(negedge clk); start = 1'b1; func = ALU_FUNC_DIVU; data1 = 4'h7; data2 = 4'h3;
    @(posedge clk);
    @(negedge clk); start = 1'b0; func = ALU_FUNC_NOP;
    check("divzero_cleared_on_accept", divzero, 0);
    n = 0;
    while (!done && n < 40) begin @(posedge clk); n++; @(negedge clk); end
    check("div_after_div0 lo", lo, 4'h2);

    // Restore a known HI/LO, then read while issuing a multiply with rd_req held.
    run_op("mthi", ALU_FUNC_MTHI, 4'hA, 4'h0, 4'hA, 4'h2, 1'b0, 0);
    run_op("mtlo", ALU_FUNC_MTLO, 4'h5, 4'h0, 4'hA, 4'h5, 1'b0, 0);
    @(negedge clk); start = 1'b1; func = ALU_FUNC_MULTU; data1 = 4'h5; data2 = 4'h3; rd_req = 1'b1;
    #0.2;
    check("idle_start_rd stall", stall, 0);
    check("idle_start_rd hi", hi, 4'hA);
    check("idle_start_rd lo", lo, 4'h5);
    @(posedge clk);
    @(negedge clk); start = 1'b0; func = ALU_FUNC_NOP;
    n = 0;
    while (!done && n < 40) begin
      if (busy) check($sformatf("stall_cycle%0d", n), stall, 1);
      if (n == 1) begin start = 1'b1; func = ALU_FUNC_MTHI; data1 = 4'hF; end
      else begin start = 1'b0; func = ALU_FUNC_NOP; end
      @(posedge clk); n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("stall_seq latency", n, EARLY ? 3 : 5);
    check("stall_seq stall_after_done", stall, 0);
    check("stall_seq hi", hi, 4'h0);
    check("stall_seq lo", lo, 4'hF);
    rd_req = 1'b0;

    // Ignored func: no busy, no done, HI/LO untouched.
    @(negedge clk); start = 1'b1; func = ALU_FUNC_ADD; data1 = 4'h3; data2 = 4'h3;
    @(posedge clk);
    @(negedge clk); start = 1'b0; func = ALU_FUNC_NOP;
    check("ignored_func busy", busy, 0);
    check("ignored_func done", done, 0);
    check("ignored_func lo", lo, 4'hF);

    // Reset at E2 aborts the multiply.
    @(negedge clk); start = 1'b1; func = ALU_FUNC_MULTU; data1 = 4'hA; data2 = 4'hA;
    @(posedge clk);
    @(negedge clk); start = 1'b0; func = ALU_FUNC_NOP;
    repeat (2) @(posedge clk);
    #0.5 rst = 1'b1;
    #0.2;
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort busy", busy, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    check("abort no_done", ndone, 0);

    fl = '{ALU_FUNC_MULT, ALU_FUNC_MULTU, ALU_FUNC_DIV, ALU_FUNC_DIVU};
    for (int i = 0; i < 200; i++) begin
      alu_func_t rf;
      rf = fl[$urandom_range(3)];
      ra = 4'($urandom);
      rb = 4'($urandom);
      model(rf, ra, rb, m_hi, m_lo, m_dz, m_lat);
      run_op($sformatf("rnd%0d %s 0x%0h,0x%0h", i, rf.name(), ra, rb), rf, ra, rb,
             m_hi, m_lo, m_dz, m_lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative multiply/divide unit; the writer side of the HI/LO register pair.
- Executes Mult/Multu/Div/Divu (and Mthi/Mtlo) over multiple cycles and commits results to HI/LO.
- Consumers read HI/LO via Mfhi/Mflo; the unit raises stall while a read would see stale data.
- Sits in the execute stage beside the single-cycle ALU; same func encoding, same ctrl bundle.

Parameters:
- DATA_W, 32, operand width; HI and LO are each DATA_W bits.
- CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden).

Ports:
- ctrl  input  `Util_Control_T  control bundle: `Util_Control_clock(ctrl)` is the single clock, `Util_Control_reset(ctrl)` is the reset, asynchronous, active-high.
- start  input  1  request valid; func/data1/data2 sampled when start=1 and busy=0.
- func  input  `Alu_Func_T  operation code (Alu_Func_* encoding).
- data1  input  DATA_W  dividend / multiplicand / Mthi-Mtlo source.
- data2  input  DATA_W  divisor / multiplier.
- rd_req  input  1  downstream issuing Mfhi/Mflo this cycle.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse on commit.
- stall  output  1  equals rd_req & busy (combinational).
- divzero  output  1  sticky; set on a divide with data2==0; cleared by the next accepted start.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- Reset, asynchronous and active-high: state=IDLE; hi, lo, busy, done and divzero are all 0.
- A reset asserted mid-operation aborts the operation; HI/LO go to 0 and no done pulse is produced.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1:
  - Mult/Multu -> MUL.
  - Div/Divu -> DIV.
  - Mthi/Mtlo: hi (or lo) <= data1 on the accept edge; done pulses the next cycle; state stays IDLE.
  - Any other func: ignored.
- Accept edge E0: latch operand magnitudes, absolute values for signed ops; record result sign and remainder sign; counter <= DATA_W.
- MUL: shift-add, one multiplier bit per edge, E1..E_DATA_W; then -> FIX.
- DIV: restoring division, one quotient bit per edge, E1..E_DATA_W; then -> FIX.
- FIX at edge E_DATA_W+1:
  - Apply two's-complement sign correction.
  - Commit {hi,lo}.
  - -> IDLE.
  - done=1 and busy=0 in the following cycle.
- Latency: DATA_W+1 edges from accept to commit.
- start while busy is ignored; the issuer must hold the request until busy=0.
- Multiply: {hi,lo} = full 2*DATA_W-bit product, signed or unsigned per func.
- Divide:
  - lo = quotient truncated toward zero.
  - hi = remainder, carrying the dividend's sign.
- Divide overflow (-2^(DATA_W-1) / -1): lo = -2^(DATA_W-1), hi = 0 (natural wrap).
- Divide by zero: no iteration. IDLE->FIX directly; commit hi = data1, lo = all-ones; set divzero.
- Simultaneous start and rd_req while IDLE: stall=0; the read sees the pre-commit HI/LO.
- busy is high from the cycle after accept through the FIX cycle inclusive.

Optional Feature:
- Macro: ALU_MULDIV_EARLY_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, go to FIX early. The remaining product shift is done in FIX, so latency = (index of highest set bit of |data2|)+2 edges. A zero multiplier takes 1 iteration. DIV timing is unchanged.
- Undefined: fixed DATA_W+1 latency for all multiplies.

Decomposition:
- Shared header/package: Alu_Func codes, Alu_Status_T, and MulDiv state encoding macros (`Alu_MulDiv_State_T`, IDLE/MUL/DIV/FIX).
- Sub-module alu_muldiv_step: combinational one-iteration datapath (add-shift for multiply, trial subtract for divide). alu_muldiv instantiates it and owns the FSM, counter, sign handling and HI/LO registers.

Test Plan (DATA_W=4, DELAY-free, clock period 2):
- Multu 0xA*0xA -> after 5 edges done=1, hi=0x6, lo=0x4; busy high for exactly 5 cycles.
- Mult 0xD(-3)*0x5 -> hi=0xF, lo=0x1; and 0x8*0xF(-8*-1) -> hi=0x0, lo=0x8.
- Divu 0x7/0x3 -> lo=0x2, hi=0x1.
- Div 0x9(-7)/0x2 -> lo=0xD(-3), hi=0xF(-1).
- Div 0x8/0xF -> lo=0x8, hi=0x0.
- Divu 0x5/0x0 -> done after 1 edge past accept; hi=0x5, lo=0xF, divzero=1.
- divzero clears on the next accepted start.
- Mulu 0x5*0x3, with rd_req=1 during busy -> stall=1 every busy cycle; start pulsed again mid-op is ignored.
- Reset pulsed at E2 -> hi=lo=0, no done pulse.
- Mthi 0xA -> hi=0xA; Mtlo 0x5 -> lo=0x5; each with done one cycle later.
- With ALU_MULDIV_EARLY_EN: Multu 0x5*0x1 -> commit at E2, hi=0x0, lo=0x5.
- Without ALU_MULDIV_EARLY_EN: the same Multu commits at E5.
